// File: rtl/calc_pkg.sv
// Shared encodings for the multi-cycle execute stage: ALU operation codes,
// operand-source select codes, multiply FSM states and the flag bundle.
package calc_pkg;

  localparam int unsigned OP_W  = 4;
  localparam int unsigned SRC_W = 2;

  typedef enum logic [OP_W-1:0] {
    OP_ADD  = 4'b0000,
    OP_SUB  = 4'b0001,
    OP_AND  = 4'b0010,
    OP_OR   = 4'b0011,
    OP_XOR  = 4'b0100,
    OP_SLL  = 4'b0101,
    OP_SRL  = 4'b0110,
    OP_SRA  = 4'b0111,
    OP_SLT  = 4'b1000,
    OP_PASS = 4'b1001,
    OP_MUL  = 4'b1010
  } alu_op_e;

  typedef enum logic [SRC_W-1:0] {
    SRCA_PC     = 2'b00,
    SRCA_ZERO   = 2'b01,
    SRCA_A      = 2'b10,
    SRCA_ALUOUT = 2'b11
  } src_a_e;

  typedef enum logic [SRC_W-1:0] {
    SRCB_B      = 2'b00,
    SRCB_PC_INC = 2'b01,
    SRCB_IMM    = 2'b10,
    SRCB_IMM_SH = 2'b11
  } src_b_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_MUL  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Condition flags; field order gives {Z,N,C,V} when viewed as 4 bits.
  typedef struct packed {
    logic z;
    logic n;
    logic c;
    logic v;
  } flags_t;

endpackage

// File: rtl/calc_alu_comb.sv
// Purely combinational single-cycle ALU with flag generation.
// Ports: a, b        - operands (after source muxes)
//        op          - operation code (calc_pkg::alu_op_e values)
//        result_c    - operation result, 0 for MUL and undefined codes
//        flags_c     - Z/N/C/V for result_c
module alu_comb
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OP_W-1:0]  op,
  output logic [WIDTH-1:0] result_c,
  output flags_t           flags_c
);

  logic [WIDTH:0]   sum_ext;
  logic [WIDTH:0]   diff_ext;
  logic [SHAMT_W-1:0] shamt;
  logic             carry;
  logic             ovf;
  logic             lt;

  // Result and arithmetic side flags per operation.
  always_comb begin
    sum_ext  = {1'b0, a} + {1'b0, b};
    diff_ext = {1'b0, a} - {1'b0, b};
    shamt    = b[SHAMT_W-1:0];
    lt       = ($signed(a) < $signed(b));
    result_c = '0;
    carry    = 1'b0;
    ovf      = 1'b0;
    case (op)
      OP_ADD: begin
        result_c = sum_ext[WIDTH-1:0];
        carry    = sum_ext[WIDTH];
        ovf      = (a[WIDTH-1] == b[WIDTH-1]) && (result_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        result_c = diff_ext[WIDTH-1:0];
        // Carry means "no borrow", i.e. a >= b unsigned.
        carry    = ~diff_ext[WIDTH];
        ovf      = (a[WIDTH-1] != b[WIDTH-1]) && (result_c[WIDTH-1] != a[WIDTH-1]);
      end
      OP_AND:  result_c = a & b;
      OP_OR:   result_c = a | b;
      OP_XOR:  result_c = a ^ b;
      OP_SLL:  result_c = a << shamt;
      OP_SRL:  result_c = a >> shamt;
      OP_SRA:  result_c = WIDTH'($signed(a) >>> shamt);
      OP_SLT:  result_c = {{(WIDTH-1){1'b0}}, lt};
      OP_PASS: result_c = b;
      default: result_c = '0;
    endcase
  end

  // Common Z/N derivation.
  always_comb begin
    flags_c   = '0;
    flags_c.z = (result_c == '0);
    flags_c.n = result_c[WIDTH-1];
    flags_c.c = carry;
    flags_c.v = ovf;
  end

endmodule

// File: rtl/calc_unit_mc.sv
// Multi-cycle execute stage: operand registers, ALU source muxes, single-cycle
// ALU, iterative shift-add multiplier, ALUOut register and sticky flags.
// Ports: clk, reset (sync, active-high)
//        input_A/B/PC/imm         - datapath sources
//        input_ALUSrcA/B, ALUOp   - source selects and operation
//        input_start              - launch multiply (with ALUOp = MUL)
//        input_FlagWrite          - update flags from this op
//        output_ALUMuxOut         - combinational result (product acc while busy)
//        output_ALUOut_sr, B_sr   - registered result and store data
//        output_Zero/negative/carry/overflow - registered flags
//        output_busy, output_done - multiply handshake
module calc_unit_mc
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned PC_INC  = 2,
  parameter int unsigned SHAMT_W = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] input_A,
  input  logic [WIDTH-1:0] input_B,
  input  logic [WIDTH-1:0] input_PC,
  input  logic [WIDTH-1:0] input_imm,
  input  logic [SRC_W-1:0] input_ALUSrcA,
  input  logic [SRC_W-1:0] input_ALUSrcB,
  input  logic [OP_W-1:0]  input_ALUOp,
  input  logic             input_start,
  input  logic             input_FlagWrite,
  output logic [WIDTH-1:0] output_ALUMuxOut,
  output logic [WIDTH-1:0] output_ALUOut_sr,
  output logic [WIDTH-1:0] output_B_sr,
  output logic             output_Zero,
  output logic             output_negative,
  output logic             output_carry,
  output logic             output_overflow,
  output logic             output_busy,
  output logic             output_done
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sr, b_sr, aluout_sr;
  logic [WIDTH-1:0] mcand_q, mplier_q, acc_q;
  logic [CNT_W-1:0] cnt_q;
  logic             fw_q;
  logic             busy_q, done_q;
  flags_t           flags_q;

  logic [WIDTH-1:0] src_a_c, src_b_c;
  logic [WIDTH-1:0] alu_res_c;
  flags_t           alu_flags_c;
  flags_t           mul_flags_c;
  logic             launch_c;
  logic             last_iter_c;

  // Operand source muxes.
  always_comb begin
    src_a_c = '0;
    src_b_c = '0;
    case (input_ALUSrcA)
      SRCA_PC:     src_a_c = input_PC;
      SRCA_ZERO:   src_a_c = '0;
      SRCA_A:      src_a_c = a_sr;
      SRCA_ALUOUT: src_a_c = aluout_sr;
      default:     src_a_c = '0;
    endcase
    case (input_ALUSrcB)
      SRCB_B:      src_b_c = b_sr;
      SRCB_PC_INC: src_b_c = WIDTH'(PC_INC);
      SRCB_IMM:    src_b_c = input_imm;
      SRCB_IMM_SH: src_b_c = {input_imm[WIDTH-2:0], 1'b0};
      default:     src_b_c = '0;
    endcase
  end

  alu_comb #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_alu (
    .a        (src_a_c),
    .b        (src_b_c),
    .op       (input_ALUOp),
    .result_c (alu_res_c),
    .flags_c  (alu_flags_c)
  );

  assign launch_c    = (state_q == ST_IDLE) && input_start && (input_ALUOp == OP_MUL);
  assign last_iter_c = (cnt_q == CNT_W'(WIDTH - 1));

  // Product flags: carry and overflow are not meaningful for the truncated product.
  always_comb begin
    mul_flags_c   = '0;
    mul_flags_c.z = (acc_q == '0);
    mul_flags_c.n = acc_q[WIDTH-1];
  end

  // Product accumulator is exposed while the multiplier owns the result path.
  assign output_ALUMuxOut = (state_q == ST_IDLE) ? alu_res_c : acc_q;

  // Multiply FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Multiply FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (launch_c)    state_d = ST_MUL;
      ST_MUL:  if (last_iter_c) state_d = ST_DONE;
      ST_DONE:                  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Operand, result and flag registers; frozen while the multiply iterates.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_sr      <= '0;
      b_sr      <= '0;
      aluout_sr <= '0;
      flags_q   <= '0;
    end else if (state_q != ST_MUL) begin
      a_sr      <= input_A;
      b_sr      <= input_B;
      aluout_sr <= output_ALUMuxOut;
      // The launch cycle does not touch flags; the product sets them at DONE.
      if (state_q == ST_DONE) begin
        if (fw_q) flags_q <= mul_flags_c;
      end else if (input_FlagWrite && !launch_c) begin
        flags_q <= alu_flags_c;
      end
    end
  end

  // Shift-add multiplier datapath.
  always_ff @(posedge clk) begin
    if (reset) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      fw_q     <= 1'b0;
    end else if (launch_c) begin
      mcand_q  <= src_a_c;
      mplier_q <= src_b_c;
      acc_q    <= '0;
      cnt_q    <= '0;
      fw_q     <= input_FlagWrite;
    end else if (state_q == ST_MUL) begin
      if (mplier_q[0]) acc_q <= acc_q + mcand_q;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CNT_W'(1);
    end
  end

  // Registered handshake outputs track the state being entered.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      busy_q <= (state_d == ST_MUL);
      done_q <= (state_d == ST_DONE);
    end
  end

  assign output_ALUOut_sr = aluout_sr;
  assign output_B_sr      = b_sr;
  assign output_Zero      = flags_q.z;
  assign output_negative  = flags_q.n;
  assign output_carry     = flags_q.c;
  assign output_overflow  = flags_q.v;
  assign output_busy      = busy_q;
  assign output_done      = done_q;

endmodule

// File: tb/tb_calc_unit_mc.sv
// Directed self-checking bench for calc_unit_mc (WIDTH=16).
module tb_calc_unit_mc;

  logic        clk;
  logic        reset;
  logic [15:0] input_A, input_B, input_PC, input_imm;
  logic [1:0]  input_ALUSrcA, input_ALUSrcB;
  logic [3:0]  input_ALUOp;
  logic        input_start, input_FlagWrite;
  logic [15:0] output_ALUMuxOut, output_ALUOut_sr, output_B_sr;
  logic        output_Zero, output_negative, output_carry, output_overflow;
  logic        output_busy, output_done;

  int          n_checks;
  int          n_fail;
  logic [15:0] mux_s;
  logic [3:0]  flags;

  assign flags = {output_Zero, output_negative, output_carry, output_overflow};

  calc_unit_mc #(.WIDTH(16), .PC_INC(2), .SHAMT_W(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .input_A          (input_A),
    .input_B          (input_B),
    .input_PC         (input_PC),
    .input_imm        (input_imm),
    .input_ALUSrcA    (input_ALUSrcA),
    .input_ALUSrcB    (input_ALUSrcB),
    .input_ALUOp      (input_ALUOp),
    .input_start      (input_start),
    .input_FlagWrite  (input_FlagWrite),
    .output_ALUMuxOut (output_ALUMuxOut),
    .output_ALUOut_sr (output_ALUOut_sr),
    .output_B_sr      (output_B_sr),
    .output_Zero      (output_Zero),
    .output_negative  (output_negative),
    .output_carry     (output_carry),
    .output_overflow  (output_overflow),
    .output_busy      (output_busy),
    .output_done      (output_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one single-cycle op: one edge loads A_sr/B_sr, mux_s samples the
  // combinational result, the second edge captures ALUOut_sr and flags.
  task automatic apply(input logic [15:0] a, input logic [15:0] b,
                       input logic [15:0] pc, input logic [15:0] imm,
                       input logic [1:0] sa, input logic [1:0] sb,
                       input logic [3:0] op, input logic fw);
    input_A = a; input_B = b; input_PC = pc; input_imm = imm;
    input_ALUSrcA = sa; input_ALUSrcB = sb; input_ALUOp = op;
    input_FlagWrite = fw; input_start = 1'b0;
    tick();
    mux_s = output_ALUMuxOut;
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    n_checks++; if (output_ALUOut_sr !== 16'h0) begin n_fail++; $display("FAIL reset_aluout: got %h want 0000", output_ALUOut_sr); end
    n_checks++; if (output_B_sr !== 16'h0) begin n_fail++; $display("FAIL reset_bsr: got %h want 0000", output_B_sr); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL reset_flags: got %b want 0000", flags); end
    n_checks++; if ({output_busy, output_done} !== 2'b00) begin n_fail++; $display("FAIL reset_handshake: got %b want 00", {output_busy, output_done}); end
    n_checks++; if (output_ALUMuxOut !== 16'h0) begin n_fail++; $display("FAIL reset_mux: got %h want 0000", output_ALUMuxOut); end
    reset = 1'b0;
  endtask

  task automatic test_add();
    apply(16'h1234, 16'h5678, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0000, 1'b1);
    n_checks++; if (mux_s !== 16'h68AC) begin n_fail++; $display("FAIL add_mux: got %h want 68ac", mux_s); end
    n_checks++; if (output_ALUOut_sr !== 16'h68AC) begin n_fail++; $display("FAIL add_out: got %h want 68ac", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL add_flags: got %b want 0000", flags); end
    n_checks++; if (output_B_sr !== 16'h5678) begin n_fail++; $display("FAIL add_bsr: got %h want 5678", output_B_sr); end
  endtask

  task automatic test_sub_flag_hold();
    apply(16'h5555, 16'h5585, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0001, 1'b1);
    n_checks++; if (output_ALUOut_sr !== 16'hFFD0) begin n_fail++; $display("FAIL sub_out: got %h want ffd0", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL sub_flags: got %b want 0100", flags); end
    apply(16'h00FF, 16'h00FF, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0100, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'h0000) begin n_fail++; $display("FAIL xor_out: got %h want 0000", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL flag_hold: got %b want 0100", flags); end
  endtask

  task automatic test_sources();
    apply(16'h7FFF, 16'h0, 16'h0, 16'h0001, 2'b10, 2'b10, 4'b0000, 1'b1);
    n_checks++; if (output_ALUOut_sr !== 16'h8000) begin n_fail++; $display("FAIL ovf_out: got %h want 8000", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b0101) begin n_fail++; $display("FAIL ovf_flags: got %b want 0101", flags); end
    apply(16'h0, 16'h0, 16'h1234, 16'h0, 2'b00, 2'b01, 4'b0000, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'h1236) begin n_fail++; $display("FAIL pc_inc: got %h want 1236", output_ALUOut_sr); end
    apply(16'h0, 16'h0, 16'h0, 16'h0003, 2'b01, 2'b11, 4'b1001, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'h0006) begin n_fail++; $display("FAIL imm_sh_pass: got %h want 0006", output_ALUOut_sr); end
    apply(16'hFFFF, 16'h0001, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0000, 1'b1);
    n_checks++; if (output_ALUOut_sr !== 16'h0000) begin n_fail++; $display("FAIL wrap_out: got %h want 0000", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b1010) begin n_fail++; $display("FAIL wrap_flags: got %b want 1010", flags); end
    // ALUOut_sr feedback: 0 -> 2 on first edge, so mux shows 4 then.
    apply(16'h0, 16'h0, 16'h0, 16'h0, 2'b11, 2'b01, 4'b0000, 1'b0);
    n_checks++; if (mux_s !== 16'h0004) begin n_fail++; $display("FAIL aluout_fb_mux: got %h want 0004", mux_s); end
    n_checks++; if (output_ALUOut_sr !== 16'h0004) begin n_fail++; $display("FAIL aluout_fb_out: got %h want 0004", output_ALUOut_sr); end
  endtask

  task automatic test_logic_shift();
    apply(16'hFFFF, 16'h0001, 16'h0, 16'h0, 2'b10, 2'b00, 4'b1000, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'h0001) begin n_fail++; $display("FAIL slt: got %h want 0001", output_ALUOut_sr); end
    apply(16'h0001, 16'h000F, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0101, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'h8000) begin n_fail++; $display("FAIL sll: got %h want 8000", output_ALUOut_sr); end
    apply(16'h8000, 16'h000F, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0110, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'h0001) begin n_fail++; $display("FAIL srl: got %h want 0001", output_ALUOut_sr); end
    apply(16'hF0F0, 16'h0FF0, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0011, 1'b0);
    n_checks++; if (output_ALUOut_sr !== 16'hFFF0) begin n_fail++; $display("FAIL or: got %h want fff0", output_ALUOut_sr); end
    apply(16'h8010, 16'h0004, 16'h0, 16'h0, 2'b10, 2'b00, 4'b0111, 1'b1);
    n_checks++; if (output_ALUOut_sr !== 16'hF801) begin n_fail++; $display("FAIL sra: got %h want f801", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b0100) begin n_fail++; $display("FAIL sra_flags: got %b want 0100", flags); end
    apply(16'h1234, 16'h5678, 16'h0, 16'h0, 2'b10, 2'b00, 4'b1100, 1'b1);
    n_checks++; if (output_ALUOut_sr !== 16'h0000) begin n_fail++; $display("FAIL undef_out: got %h want 0000", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL undef_flags: got %b want 1000", flags); end
  endtask

  // Ends sampled in the DONE cycle with start raised for the next multiply.
  task automatic test_mul();
    int busy_bad;
    busy_bad = 0;
    input_A = 16'h0123; input_B = 16'h0010; input_ALUSrcA = 2'b10; input_ALUSrcB = 2'b00;
    input_ALUOp = 4'b1010; input_FlagWrite = 1'b1; input_start = 1'b0;
    tick();
    input_start = 1'b1;
    tick();
    input_start = 1'b0;
    input_A = 16'hFFFF; input_B = 16'hFFFF;
    for (int i = 1; i <= 16; i++) begin
      if (output_busy !== 1'b1 || output_done !== 1'b0) busy_bad++;
      if (i == 8) begin
        n_checks++; if (output_B_sr !== 16'h0010) begin n_fail++; $display("FAIL mul_bsr_frozen: got %h want 0010", output_B_sr); end
        n_checks++; if (flags !== 4'b1000) begin n_fail++; $display("FAIL mul_flags_busy: got %b want 1000", flags); end
      end
      tick();
    end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL mul_busy_window: got %0d bad cycles want 0", busy_bad); end
    n_checks++; if ({output_busy, output_done} !== 2'b01) begin n_fail++; $display("FAIL mul_done_pulse: got %b want 01", {output_busy, output_done}); end
    n_checks++; if (output_ALUMuxOut !== 16'h1230) begin n_fail++; $display("FAIL mul_acc: got %h want 1230", output_ALUMuxOut); end
    input_start = 1'b1;
  endtask

  task automatic test_back_to_back();
    int busy_bad;
    busy_bad = 0;
    tick();
    n_checks++; if ({output_busy, output_done} !== 2'b00) begin n_fail++; $display("FAIL b2b_start_ignored: got %b want 00", {output_busy, output_done}); end
    n_checks++; if (output_ALUOut_sr !== 16'h1230) begin n_fail++; $display("FAIL mul_out: got %h want 1230", output_ALUOut_sr); end
    n_checks++; if (flags !== 4'b0000) begin n_fail++; $display("FAIL mul_flags: got %b want 0000", flags); end
    tick();
    input_start = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      if (output_busy !== 1'b1 || output_done !== 1'b0) busy_bad++;
      tick();
    end
    n_checks++; if (busy_bad != 0) begin n_fail++; $display("FAIL b2b_busy_window: got %0d bad cycles want 0", busy_bad); end
    n_checks++; if (output_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", output_done); end
    tick();
    n_checks++; if (output_ALUOut_sr !== 16'h0001) begin n_fail++; $display("FAIL mul_ffff: got %h want 0001", output_ALUOut_sr); end
    n_checks++; if (output_done !== 1'b0) begin n_fail++; $display("FAIL done_one_cycle: got %b want 0", output_done); end
  endtask

  task automatic test_reset_abort();
    int stray;
    stray = 0;
    apply(16'hFFFF, 16'hFFFF, 16'h0, 16'h0, 2'b10, 2'b00, 4'b1100, 1'b1);
    input_ALUOp = 4'b1010; input_FlagWrite = 1'b0; input_start = 1'b1;
    tick();
    input_start = 1'b0;
    for (int i = 1; i < 5; i++) tick();
    n_checks++; if (output_busy !== 1'b1) begin n_fail++; $display("FAIL abort_busy5: got %b want 1", output_busy); end
    reset = 1'b1;
    tick();
    n_checks++; if ({output_busy, output_done, flags} !== 6'b0) begin n_fail++; $display("FAIL abort_ctrl_flags: got %b want 000000", {output_busy, output_done, flags}); end
    n_checks++; if ({output_ALUOut_sr, output_B_sr, output_ALUMuxOut} !== 48'h0) begin n_fail++; $display("FAIL abort_data: got %h want 0", {output_ALUOut_sr, output_B_sr, output_ALUMuxOut}); end
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (output_done !== 1'b0 || output_busy !== 1'b0) stray++;
      tick();
    end
    n_checks++; if (stray != 0) begin n_fail++; $display("FAIL abort_no_done: got %0d stray cycles want 0", stray); end
  endtask

  initial begin
    n_checks = 0; n_fail = 0; mux_s = '0;
    reset = 1'b1; input_A = '0; input_B = '0; input_PC = '0; input_imm = '0;
    input_ALUSrcA = '0; input_ALUSrcB = '0; input_ALUOp = '0;
    input_start = 1'b0; input_FlagWrite = 1'b0;
    test_reset();
    test_add();
    test_sub_flag_hold();
    test_sources();
    test_logic_shift();
    test_mul();
    test_back_to_back();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/calc_unit_mc.md
Name: calc_unit_mc

Overview:
Parametrised next-generation execute stage for the multi-cycle datapath. It registers A/B operands, selects ALU sources via ALUSrcA/ALUSrcB muxes, and computes single-cycle ALU ops plus an iterative shift-add multiply with a start/busy/done handshake. It holds an ALUOut register and a sticky flag register (Z/N/C/V) that is written only on FlagWrite. It sits between the register file and the writeback/PC mux.

Parameters:
WIDTH, 16, datapath width in bits (>=4)
PC_INC, 2, constant selected by ALUSrcB=01
SHAMT_W, 4, shift-amount bits taken from operand B LSBs (= clog2(WIDTH))

Ports:
clk  in  1  system clock, all state on rising edge
reset  in  1  synchronous, active-high reset
input_A  in  WIDTH  register-file port A
input_B  in  WIDTH  register-file port B
input_PC  in  WIDTH  current PC
input_imm  in  WIDTH  sign-extended immediate
input_ALUSrcA  in  2  00 PC, 01 zero, 10 A_sr, 11 ALUOut_sr
input_ALUSrcB  in  2  00 B_sr, 01 PC_INC, 10 imm, 11 imm<<1
input_ALUOp  in  4  operation code
input_start  in  1  launch multi-cycle op (MUL)
input_FlagWrite  in  1  update flag register with this op's flags
output_ALUMuxOut  out  WIDTH  combinational ALU result (product acc. while busy)
output_ALUOut_sr  out  WIDTH  registered ALU result
output_B_sr  out  WIDTH  registered B (store data)
output_Zero  out  1  registered zero flag
output_negative  out  1  registered negative flag
output_carry  out  1  registered carry/no-borrow flag
output_overflow  out  1  registered signed overflow flag
output_busy  out  1  multiply in progress
output_done  out  1  one-cycle pulse on multiply completion

Behaviour:
- Reset: A_sr, B_sr, ALUOut_sr, product accumulator, counter = 0; all flags 0; busy=0; done=0; FSM -> IDLE. Reset mid-multiply aborts it, no done pulse.
- A_sr<=input_A, B_sr<=input_B every cycle when not busy; frozen while busy.
- Ops (operands a=SrcA mux, b=SrcB mux): 0000 add; 0001 sub (a-b); 0010 and; 0011 or; 0100 xor; 0101 sll a by b[SHAMT_W-1:0]; 0110 srl; 0111 sra; 1000 slt signed (result 1/0); 1001 pass b; 1010 mul (multi-cycle); 1011-1111 result 0, flags Z=1 others 0.
- Arithmetic: add/sub computed WIDTH+1 bits; C = carry-out (add) or NOT borrow (sub, a>=b unsigned); V = signed overflow for add/sub, 0 for all other ops; Z = (result==0); N = result[WIDTH-1].
- Single-cycle: ALUMuxOut combinational same cycle; ALUOut_sr<=ALUMuxOut every non-busy cycle; flags <= new flags on that edge iff input_FlagWrite, else hold.
- FSM IDLE/MUL/DONE:
  IDLE: input_start && ALUOp==1010 -> latch a into multiplicand, b into multiplier, acc=0, cnt=0, capture FlagWrite -> MUL. input_start with any other op ignored (treated as single-cycle).
  MUL: busy=1; each cycle if multiplier[0] acc+=multiplicand; multiplicand<<=1; multiplier>>=1; cnt++; after WIDTH iterations -> DONE. input_start ignored while busy.
  DONE: busy=0, done=1 for exactly one cycle; ALUOut_sr <= acc (low WIDTH bits of product); flags updated from product if captured FlagWrite (C=V=0) -> IDLE. Latency start->done = WIDTH+1 cycles.
- ALUMuxOut during MUL/DONE = acc.
- Back-to-back: start asserted in the DONE cycle is ignored; accepted next IDLE cycle.
- Wrap-around: add/sub results modulo 2^WIDTH; mul keeps low WIDTH bits only.
- Shift amount >= WIDTH impossible by construction (SHAMT_W bits).

Decomposition:
- Package calc_pkg: ALUOp encodings, ALUSrcA/ALUSrcB encodings, FSM state encoding.
- Sub-module alu_comb (purely combinational op + flags) instantiated by calc_unit_mc; multiply FSM, operand and flag registers stay in top.

Test Plan:
- W=16, A=0x1234, B=0x5678, SrcA=10, SrcB=00, op add, FlagWrite=1 -> ALUMuxOut=0x68AC, after edge ALUOut_sr=0x68AC, Z=N=C=V=0.
- A=0x5555, B=0x5585, sub, FlagWrite=1 -> 0xFFD0, N=1, C=0, Z=0; next op with FlagWrite=0 leaves flags unchanged.
- A=0x7FFF, imm=0x0001, SrcB=10, add -> 0x8000, V=1, N=1; SrcA=00 PC=0x1234, SrcB=01 -> 0x1236.
- A=0x0123, B=0x0010, op mul, start 1 cycle -> busy high 16 cycles, done pulse at cycle 17, ALUOut_sr=0x1230; A/B changes during busy ignored.
- mul 0xFFFF*0xFFFF -> ALUOut_sr=0x0001; reset asserted at busy cycle 5 -> busy=0, done never pulses, all outputs 0 next cycle.
- sra A=0x8010 by B=0x0004 -> 0xF801; undefined op 1100 -> result 0, Z=1.
